// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core datapath and a 32-bit valid/ready data bus.
// One transaction at a time: request, optional read response, then a single DONE or ERR cycle.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        TimeoutErr,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_R = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;
  logic        op_s;
  logic        bad_s;
  logic        last_s;

  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Illegal width code or an address not aligned to the access size.
  function automatic logic op_bad(input logic is_wr, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic mis;
    if (is_wr) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
    mis = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    return !legal || mis;
  endfunction

  assign op_s   = MemRead | MemWrite;
  assign bad_s  = op_bad(MemWrite, Funct3, ALUResult[1:0]);
  assign last_s = (cnt_q == TMO_LAST);

  // Next-state, request capture, read capture and error-pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (!op_s) begin
          state_d = S_IDLE;
        end else if (bad_s) begin
          state_d = S_ERR;
          mis_d   = 1'b1;
        end else begin
          state_d = S_REQ;
          addr_d  = {ALUResult[31:2], 2'b00};
          we_d    = MemWrite;
          f3_d    = Funct3;
          off_d   = ALUResult[1:0];
          wstrb_d = MemWrite ? lane_strb(Funct3, ALUResult[1:0]) : 4'b0000;
          wdata_d = MemWrite ? lane_data(Funct3, WriteData) : 32'h0000_0000;
        end
      end
      // A handshake or response in the final budgeted cycle still completes normally.
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_ready) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
        end else if (last_s) begin
          state_d = S_ERR;
          tmo_d   = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT_R: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_rvalid) begin
          state_d = S_DONE;
          rdata_d = load_extend(f3_q, off_q, bus_rdata);
        end else if (last_s) begin
          state_d = S_ERR;
          tmo_d   = 1'b1;
        end else begin
          state_d = S_WAIT_R;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_REQ);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      addr_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign Stall       = op_s & ((state_q == S_IDLE) | (state_q == S_REQ) | (state_q == S_WAIT_R));
  assign ReadData    = rdata_q;
  assign MisalignErr = mis_q;
  assign TimeoutErr  = tmo_q;
  assign bus_valid   = valid_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wstrb   = wstrb_q;
  assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed scoreboard bench for lsu_bus_bridge: request fields and load results are
// predicted when an op is driven and compared when the bus/DONE cycle shows them.
module tb_lsu_bus_bridge;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Stall, MisalignErr, TimeoutErr, bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .MisalignErr(MisalignErr), .TimeoutErr(TimeoutErr), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_bad(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    int   sz;
    legal = wr ? (f3 <= 3'd2) : !((f3 == 3'b011) || (f3[2:1] == 2'b11));
    sz = 1 << f3[1:0];
    return !legal || ((int'(off) % sz) != 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (f3[1:0])
      2'b00:   s[off] = 1'b1;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = word >> (8 * int'(off));
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return 32'(shw);
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Runs one op from IDLE; kind 0 = completes, 1 = misalign/illegal, 2 = timeout.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                       input int ready_lo, input int rv_dly, input bit early_rv);
    int   kind;
    int   exp_stall;
    int   stall_cnt;
    int   req_cycles;
    int   wait_cnt;
    bit   accepted;
    bit   saw_valid;
    bit   done;
    req_t r;
    stall_cnt = 0; req_cycles = 0; wait_cnt = 0;
    accepted = 1'b0; saw_valid = 1'b0; done = 1'b0;
    if (m_bad(wr, f3, addr[1:0])) kind = 1;
    else if (!wr && rv_dly < 0) kind = 2;
    else kind = 0;
    if (kind == 1) exp_stall = 1;
    else if (kind == 2) exp_stall = 1 + TMO;
    else if (wr) exp_stall = 2 + ready_lo;
    else exp_stall = 2 + ready_lo + rv_dly;
    if (kind != 1) begin
      r.we    = wr;
      r.addr  = {addr[31:2], 2'b00};
      r.wstrb = wr ? m_strb(f3, addr[1:0]) : 4'b0000;
      r.wdata = wr ? m_wdata(f3, wd) : 32'h0;
      exp_req_q.push_back(r);
    end
    if (kind == 0 && !wr) exp_rd_q.push_back(m_load(f3, addr[1:0], rdata));
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1'b1;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        chk({tag, "/misalign_err"}, 32'(MisalignErr), 32'(kind == 1));
        chk({tag, "/timeout_err"}, 32'(TimeoutErr), 32'(kind == 2));
        chk({tag, "/valid_in_end"}, 32'(bus_valid), 32'h0);
        chk({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "/saw_valid"}, 32'(saw_valid), 32'(kind != 1));
        if (kind == 0 && !wr && exp_rd_q.size() > 0) last_rd = exp_rd_q.pop_front();
        chk({tag, "/read_data"}, ReadData, last_rd);
      end else begin
        stall_cnt++;
        if (bus_valid) begin
          saw_valid = 1'b1;
          if (exp_req_q.size() == 0) begin
            chk({tag, "/unexpected_valid"}, 32'(bus_valid), 32'h0);
          end else begin
            r = exp_req_q[0];
            chk({tag, "/bus_we"}, 32'(bus_we), 32'(r.we));
            chk({tag, "/bus_addr"}, bus_addr, r.addr);
            chk({tag, "/bus_wstrb"}, 32'(bus_wstrb), 32'(r.wstrb));
            chk({tag, "/bus_wdata"}, bus_wdata, r.wdata);
          end
          bus_ready  = (req_cycles >= ready_lo);
          req_cycles++;
          bus_rvalid = bus_ready & early_rv;
          bus_rdata  = ~rdata;
          if (bus_ready) begin
            accepted = 1'b1;
            if (exp_req_q.size() > 0) void'(exp_req_q.pop_front());
            if (ready_lo > 0) chk({tag, "/handshake_cycle"}, 32'(req_cycles), 32'(ready_lo + 1));
          end
        end else begin
          bus_ready = 1'b0;
          if (accepted) begin
            wait_cnt++;
            bus_rvalid = (wait_cnt == rv_dly);
            bus_rdata  = rdata;
          end else begin
            bus_rvalid = 1'b0;
          end
        end
      end
    end
    if (!done) chk({tag, "/no_completion"}, 32'(Stall), 32'h0);
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/stall"}, 32'(Stall), 32'h0);
    chk({tag, "/valid"}, 32'(bus_valid), 32'h0);
    chk({tag, "/we"}, 32'(bus_we), 32'h0);
    chk({tag, "/addr"}, bus_addr, 32'h0);
    chk({tag, "/wstrb"}, 32'(bus_wstrb), 32'h0);
    chk({tag, "/wdata"}, bus_wdata, 32'h0);
    chk({tag, "/rdata"}, ReadData, 32'h0);
    chk({tag, "/mis"}, 32'(MisalignErr), 32'h0);
    chk({tag, "/tmo"}, 32'(TimeoutErr), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_op("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    do_op("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 0, 2, 1'b1);
    do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF_7F01, 1, 1, 1'b0);
    do_op("lb0", 1'b1, 1'b0, 3'b000, 32'h500, 32'h0, 32'h1234_5678, 0, 1, 1'b0);
    do_op("sh",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
    do_op("sb",  1'b0, 1'b1, 3'b000, 32'h301, 32'hFFFF_FF5A, 32'h0, 0, 0, 1'b0);
    do_op("sw_both", 1'b1, 1'b1, 3'b010, 32'h10, 32'hA5A5_5A5A, 32'h0, 0, 0, 1'b0);
    do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h201, 32'h0, 32'h0, 0, 1, 1'b0);
    do_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op("ld_ill", 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0);
    do_op("st_ill", 1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op("sw_wait", 1'b0, 1'b1, 3'b010, 32'h3F0, 32'h0102_0304, 32'h0, 3, 0, 1'b0);

    do_op("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 0, -1, 1'b0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_rv/rdata", ReadData, last_rd);
    chk("late_rv/valid", 32'(bus_valid), 32'h0);
    @(negedge clk);
    chk("late_rv/rdata2", ReadData, last_rd);
    chk("late_rv/tmo", 32'(TimeoutErr), 32'h0);
    bus_rvalid = 1'b0;
    @(posedge clk);
    #1;

    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h40; bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid/req_valid", 32'(bus_valid), 32'h1);
    @(negedge clk);
    chk("rst_mid/wait_stall", 32'(Stall), 32'h1);
    chk("rst_mid/wait_valid", 32'(bus_valid), 32'h0);
    reset = 1'b0; MemRead = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    reset = 1'b1;
    last_rd = 32'h0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    @(negedge clk);
    chk("rst_mid/stale_rv", ReadData, 32'h0);
    chk("rst_mid/idle_valid", 32'(bus_valid), 32'h0);
    bus_rvalid = 1'b0;
    @(posedge clk);
    #1;
    do_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0);

    chk("sb_req_empty", 32'(exp_req_q.size()), 32'h0);
    chk("sb_rd_empty", 32'(exp_rd_q.size()), 32'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
